serial_tx_piso: RTL and testbench

- Parallel-in/serial-out transmitter: accepts one WIDTH-bit word over a valid/ready handshake, then shifts it out one bit per clock with a frame-qualifier strobe.
- Transmit-side counterpart of the team's serial-capture flip-flop chains.
- Sits between a parallel producer (register file or FIFO) and a single-wire serial link sampled by a receiver on the same clock.

---
 rtl/serial_tx_piso.sv | 141 ++++++++++++++
 tb/tb_serial_tx_piso.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_piso.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_piso
// Description : Parallel-in/serial-out transmitter. Accepts one WIDTH-bit word
//               over a valid/ready handshake, then shifts it out one bit per
//               clock together with a frame strobe (sframe) and a last-bit
//               strobe (slast).
// Ports       : clock      - system clock, rising edge
//               clearb     - asynchronous active-low reset
//               load_valid - producer has a word on load_data
//               load_data  - word to send, sampled on the accepting edge
//               load_ready - transmitter can accept a word this cycle (comb.)
//               abort      - synchronous frame cancel
//               sdata      - serial data bit (registered, 0 when idle)
//               sframe     - high while sdata carries a frame bit (registered)
//               slast      - high during the final bit of a frame (registered)
//               busy       - frame in progress, identical to sframe
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clearb,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic             sdata,
  output logic             sframe,
  output logic             slast,
  output logic             busy
);

  localparam int              c_CW     = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST   = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_PENULT = c_CW'(WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]  r_shift, w_shift_nxt;
  logic              r_sdata, w_sdata_nxt;
  logic              r_sframe, w_sframe_nxt;
  logic              r_slast, w_slast_nxt;

  logic              w_at_last;
  logic              w_accept;
  logic              w_first_bit;
  logic              w_next_bit;
  logic [WIDTH-1:0]  w_load_rest;
  logic [WIDTH-1:0]  w_shift_rest;

  // The first bit goes straight to the sdata register on the accepting edge;
  // the shift register only holds the bits still to be sent, aligned so the
  // next one always sits at the outgoing end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit  = load_data[WIDTH-1];
      assign w_load_rest  = {load_data[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shift[WIDTH-1];
      assign w_shift_rest = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = load_data[0];
      assign w_load_rest  = {1'b0, load_data[WIDTH-1:1]};
      assign w_next_bit   = r_shift[0];
      assign w_shift_rest = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign w_at_last = (r_state == SHIFT) && (r_cnt == c_LAST);

  // Gated by clearb so nothing can look acceptable while reset is asserted.
  assign load_ready = clearb & ~abort & ((r_state == IDLE) | w_at_last);
  assign w_accept   = load_valid & load_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_sdata_nxt  = 1'b0;
    w_sframe_nxt = 1'b0;
    w_slast_nxt  = 1'b0;

    if (abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
    end else if (w_accept) begin
      // Covers both a start from IDLE and a back-to-back start in the
      // slast cycle; WIDTH >= 2 so bit 0 is never also the last bit.
      w_state_nxt  = SHIFT;
      w_cnt_nxt    = '0;
      w_shift_nxt  = w_load_rest;
      w_sdata_nxt  = w_first_bit;
      w_sframe_nxt = 1'b1;
    end else if (r_state == SHIFT) begin
      if (w_at_last) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_shift_nxt = '0;
      end else begin
        w_cnt_nxt    = r_cnt + 1'b1;
        w_shift_nxt  = w_shift_rest;
        w_sdata_nxt  = w_next_bit;
        w_sframe_nxt = 1'b1;
        w_slast_nxt  = (r_cnt == c_PENULT);
      end
    end
  end

  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_sdata  <= 1'b0;
      r_sframe <= 1'b0;
      r_slast  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_sdata  <= w_sdata_nxt;
      r_sframe <= w_sframe_nxt;
      r_slast  <= w_slast_nxt;
    end
  end

  assign sdata  = r_sdata;
  assign sframe = r_sframe;
  assign slast  = r_slast;
  assign busy   = r_sframe;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_piso.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_piso
// Description : Self-checking bench for serial_tx_piso. Two instances (MSB
//               first and LSB first, WIDTH=8) share all inputs and are
//               compared every cycle against a frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_piso;

  logic       clock = 1'b0;
  logic       clearb;
  logic       load_valid;
  logic [7:0] load_data;
  logic       abort;

  logic ready_m, sdata_m, sframe_m, slast_m, busy_m;
  logic ready_l, sdata_l, sframe_l, slast_l, busy_l;

  serial_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clock(clock), .clearb(clearb), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready_m), .abort(abort),
    .sdata(sdata_m), .sframe(sframe_m), .slast(slast_m), .busy(busy_m)
  );

  serial_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clock(clock), .clearb(clearb), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready_l), .abort(abort),
    .sdata(sdata_l), .sframe(sframe_l), .slast(slast_l), .busy(busy_l)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which word is on the line and which bit position of it.
  bit         m_active;
  int         m_k;
  logic [7:0] m_word;
  bit         last_acc;

  function automatic logic exp_ready();
    return clearb && !abort && (!m_active || m_k == 7);
  endfunction

  // {ready, sdata, sframe, slast, busy} for MSB instance, then LSB instance.
  function automatic logic [9:0] exp_vec();
    logic f, l, dm, dl, r;
    f  = clearb && m_active;
    l  = f && (m_k == 7);
    dm = f ? m_word[7 - m_k] : 1'b0;
    dl = f ? m_word[m_k]     : 1'b0;
    r  = exp_ready();
    return {r, dm, f, l, f, r, dl, f, l, f};
  endfunction

  function automatic logic [9:0] got_vec();
    return {ready_m, sdata_m, sframe_m, slast_m, busy_m,
            ready_l, sdata_l, sframe_l, slast_l, busy_l};
  endfunction

  // Advance one clock: update the model with the inputs seen at the edge,
  // then return to the falling edge where new inputs are driven.
  task automatic tick();
    bit acc;
    acc = exp_ready() && load_valid;
    @(posedge clock);
    last_acc = 1'b0;
    if (!clearb) begin
      m_active = 1'b0;
      m_k      = 0;
    end else if (abort) begin
      m_active = 1'b0;
      m_k      = 0;
    end else if (acc) begin
      m_active = 1'b1;
      m_k      = 0;
      m_word   = load_data;
      last_acc = 1'b1;
    end else if (m_active) begin
      if (m_k == 7) m_active = 1'b0;
      else          m_k      = m_k + 1;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    clearb = 1'b0; load_valid = 1'b1; abort = 1'b0; load_data = 8'($urandom);
    m_active = 1'b0; m_k = 0; m_word = '0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      load_data = 8'($urandom);
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      tick();
    end
    clearb = 1'b1; load_data = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL release[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      tick();
      if (i == 0) begin
        n_cmp++;
        if (sframe_m !== 1'b1) begin
          n_bad++;
          $display("FAIL first_accept sframe got=%b exp=1", sframe_m);
        end
      end
      load_valid = 1'b0;
    end
  endtask

  task automatic test_single_msb();
    logic [7:0] bits;
    int nf, nl;
    bits = '0; nf = 0; nl = 0;
    load_valid = 1'b1; load_data = 8'hA5;
    for (int i = 0; i < 11; i++) begin
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL single_msb[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      if (sframe_m) begin
        bits = {bits[6:0], sdata_m};
        nf++;
        if (slast_m) nl = nf;
      end
      tick();
      load_valid = 1'b0;
    end
    n_cmp++;
    if (bits !== 8'hA5 || nf != 8 || nl != 8) begin
      n_bad++;
      $display("FAIL single_msb_stream got=%h/%0d/%0d exp=a5/8/8", bits, nf, nl);
    end
  endtask

  task automatic test_single_lsb();
    logic [7:0] seq;
    int nf;
    seq = '0; nf = 0;
    load_valid = 1'b1; load_data = 8'h01;
    for (int i = 0; i < 11; i++) begin
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL single_lsb[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      if (sframe_l) begin
        seq = {seq[6:0], sdata_l};
        nf++;
      end
      tick();
      load_valid = 1'b0;
    end
    n_cmp++;
    if (seq !== 8'b1000_0000 || nf != 8) begin
      n_bad++;
      $display("FAIL single_lsb_stream got=%b/%0d exp=10000000/8", seq, nf);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [15:0] bits;
    int nf, nl, run, max_run;
    q = '{8'hF0, 8'h0F};
    bits = '0; nf = 0; nl = 0; run = 0; max_run = 0;
    for (int i = 0; i < 22; i++) begin
      load_valid = (q.size() > 0);
      load_data  = (q.size() > 0) ? q[0] : 8'($urandom);
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL b2b[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      if (sframe_m) begin
        bits = {bits[14:0], sdata_m};
        nf++;
        run++;
        if (slast_m) nl++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      tick();
      if (last_acc) void'(q.pop_front());
    end
    load_valid = 1'b0;
    n_cmp++;
    if (bits !== 16'hF00F || nf != 16 || nl != 2 || max_run != 16) begin
      n_bad++;
      $display("FAIL b2b_stream got=%h/%0d/%0d/%0d exp=f00f/16/2/16",
               bits, nf, nl, max_run);
    end
  endtask

  task automatic test_abort();
    logic [7:0] q[$];
    bit done_abort;
    int gap, gap_seen, nf2;
    bit in_gap, second;
    q = '{8'hFF, 8'h5A};
    done_abort = 1'b0; gap = 0; gap_seen = -1; in_gap = 1'b0; second = 1'b0; nf2 = 0;
    for (int i = 0; i < 25; i++) begin
      abort = (m_active && m_k == 3 && !done_abort);
      if (abort) done_abort = 1'b1;
      load_valid = (q.size() > 0);
      load_data  = (q.size() > 0) ? q[0] : 8'($urandom);
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL abort[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      if (done_abort && !abort && !second) begin
        if (!sframe_m) gap++;
        else begin second = 1'b1; gap_seen = gap; end
      end
      if (second && sframe_m) nf2++;
      tick();
      if (last_acc) void'(q.pop_front());
    end
    abort = 1'b0; load_valid = 1'b0;
    n_cmp++;
    if (gap_seen != 1 || nf2 != 8) begin
      n_bad++;
      $display("FAIL abort_gap got=%0d/%0d exp=1/8", gap_seen, nf2);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    load_valid = 1'b1; load_data = 8'($urandom);
    #1;
    tick();
    load_valid = 1'b0;
    guard = 0;
    while (!(m_active && m_k == 5) && guard < 20) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_bad++;
      $display("FAIL async_setup got=timeout exp=bit5");
    end
    #2;
    clearb = 1'b0;
    #1;
    n_cmp++;
    if ({sdata_m, sframe_m, slast_m, busy_m, ready_m, sframe_l} !== 6'b0) begin
      n_bad++;
      $display("FAIL async_reset got=%b exp=000000",
               {sdata_m, sframe_m, slast_m, busy_m, ready_m, sframe_l});
    end
    m_active = 1'b0; m_k = 0;
    @(negedge clock);
    tick();
    clearb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec() || sframe_m !== 1'b0) begin
        n_bad++;
        $display("FAIL async_idle[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 9) < 7);
      load_data  = 8'($urandom);
      abort      = ($urandom_range(0, 19) == 0);
      #1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random[%0d] got=%b exp=%b", i, got_vec(), exp_vec());
      end
      tick();
    end
    abort = 1'b0; load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_single_lsb();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
